// File: rtl/multicycle_core.sv
// Multi-cycle RV32I/RV64I subset core (ADDI/ADD/SUB/LUI/AUIPC/JAL/JALR/EBREAK) with FETCH/EXEC/HALT/TRAP FSM.
// Latency: 2 cycles per instruction minimum; FETCH holds imem_req and a stable imem_addr until imem_valid.
module multicycle_core #(
    parameter int               XLEN     = 64,
    parameter int               NREGS    = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic             retire,
    output logic [XLEN-1:0]  retire_pc,
    output logic [63:0]      instret,
    output logic             halted,
    output logic             trap
);

    localparam int RW = (NREGS == 16) ? 4 : 5;

    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [63:0]       instret_q, instret_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   i_imm, u_imm, j_imm;
    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic [XLEN-1:0]   pc_plus4, jalr_sum;

    logic              legal, reg_ok, illegal, misaligned;
    logic              uses_rd, uses_rs1, uses_rs2;
    logic              is_jump, is_ebreak;
    logic [XLEN-1:0]   result, target;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign i_imm = XLEN'($signed(ir_q[31:20]));
    assign u_imm = XLEN'($signed({ir_q[31:12], 12'b0}));
    assign j_imm = XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));

    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1[RW-1:0]];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2[RW-1:0]];
    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = rs1_val + i_imm;

    // Decode and execute; register indices only matter for the fields an instruction actually uses.
    always_comb begin
        legal     = 1'b0;
        uses_rd   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        is_jump   = 1'b0;
        is_ebreak = 1'b0;
        result    = '0;
        target    = pc_plus4;
        case (opcode)
            OPC_OPIMM: begin
                if (funct3 == 3'b000) begin
                    legal    = 1'b1;
                    uses_rd  = 1'b1;
                    uses_rs1 = 1'b1;
                    result   = rs1_val + i_imm;
                end
            end
            OPC_OP: begin
                if (funct3 == 3'b000 && (funct7 == 7'h00 || funct7 == 7'h20)) begin
                    legal    = 1'b1;
                    uses_rd  = 1'b1;
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                    result   = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
                end
            end
            OPC_LUI: begin
                legal   = 1'b1;
                uses_rd = 1'b1;
                result  = u_imm;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                uses_rd = 1'b1;
                result  = pc_q + u_imm;
            end
            OPC_JAL: begin
                legal   = 1'b1;
                uses_rd = 1'b1;
                is_jump = 1'b1;
                result  = pc_plus4;
                target  = pc_q + j_imm;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    legal    = 1'b1;
                    uses_rd  = 1'b1;
                    uses_rs1 = 1'b1;
                    is_jump  = 1'b1;
                    result   = pc_plus4;
                    target   = {jalr_sum[XLEN-1:1], 1'b0};
                end
            end
            default: begin
                if (ir_q == INSN_EBREAK) begin
                    legal     = 1'b1;
                    is_ebreak = 1'b1;
                end
            end
        endcase

        reg_ok = (NREGS == 32) ||
                 !((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]));
        illegal    = !legal || !reg_ok;
        misaligned = is_jump && target[1];
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = result;
        case (state_q)
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // A faulting instruction leaves pc, rd and instret untouched.
                if (illegal || misaligned) begin
                    state_d = S_TRAP;
                end else begin
                    rf_we     = uses_rd;
                    pc_d      = target;
                    instret_d = instret_q + 64'd1;
                    state_d   = is_ebreak ? S_HALT : S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs_q[rf_waddr[RW-1:0]] <= rf_wdata;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign retire    = (state_q == S_EXEC) && !illegal && !misaligned;
    assign retire_pc = pc_q;
    assign instret   = instret_q;
    assign halted    = (state_q == S_HALT);
    assign trap      = (state_q == S_TRAP);

endmodule
